pool_2d: RTL and testbench



---
 rtl/pool_pkg.sv | 28 ++
 rtl/pool_hreduce.sv | 51 +++++
 rtl/pool_2d.sv | 150 +++++++++++++++
 tb/tb_pool_2d.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared encodings, state type and width helpers for the 2-D pooling stage.
package pool_pkg;

   localparam logic POOL_AVG = 1'b0;
   localparam logic POOL_MAX = 1'b1;

   // Largest supported window exponent (K = 4).
   localparam int MAX_LG = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } pool_state_e;

   function automatic int acc_width(input int dwidth, input int max_win);
      return dwidth + 2 * $clog2(max_win);
   endfunction

   function automatic logic [1:0] win_log2(input logic [2:0] k);
      case (k)
         3'd2:    return 2'd1;
         3'd4:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pool_hreduce.sv
// Combinational horizontal reduce of one accumulator row into K-lane groups;
// zero latency, no flow control of its own.
module pool_hreduce
   import pool_pkg::*;
#(
   parameter int DESIGN_SIZE = 16,
   parameter int ACC_W       = 12,
   parameter int DWIDTH      = 8
) (
   input  logic                              mode,
   input  logic [1:0]                        win_lg,
   input  logic [DESIGN_SIZE-1:0][ACC_W-1:0] acc,
   input  logic [DESIGN_SIZE-1:0]            lane_vld,
   output logic [DESIGN_SIZE*DWIDTH-1:0]     dat
);

   localparam int SUM_W = ACC_W + 2 * MAX_LG;

   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] avg;
   logic signed [ACC_W-1:0] mx;
   logic                    any;

   always_comb begin
      dat = '0;
      sum = '0;
      avg = '0;
      mx  = '0;
      any = 1'b0;
      for (int g = 0; g <= MAX_LG; g++) begin
         if (int'(win_lg) == g) begin
            for (int j = 0; j < (DESIGN_SIZE >> g); j++) begin
               sum = '0;
               mx  = {1'b1, {(ACC_W-1){1'b0}}};
               any = 1'b0;
               for (int t = 0; t < (1 << g); t++) begin
                  sum = sum + SUM_W'($signed(acc[(j << g) + t]));
                  if ($signed(acc[(j << g) + t]) > mx)
                     mx = acc[(j << g) + t];
                  any = any | lane_vld[(j << g) + t];
               end
               // Arithmetic shift floors toward minus infinity; divisor is always K*K.
               avg = sum >>> (2 * g);
               if (any)
                  dat[j*DWIDTH +: DWIDTH] = (mode == POOL_MAX) ? DWIDTH'(mx) : DWIDTH'(avg);
            end
         end
      end
   end

endmodule

// File: rtl/pool_2d.sv
// 2-D average/max pooling; output row registered the cycle after a window's last row.
// Input stalls while a pooled row waits on out_ready; enable_pool = 0 is a combinational bypass.
module pool_2d
   import pool_pkg::*;
#(
   parameter int DESIGN_SIZE = 16,
   parameter int DWIDTH      = 8,
   parameter int MAX_WIN     = 4,
   parameter int ROW_CNT_W   = 16
) (
   input  logic                          core_clk,
   input  logic                          arst_n,
   input  logic                          enable_pool,
   input  logic                          start,
   input  logic                          pool_mode,
   input  logic [2:0]                    pool_window_size,
   input  logic [ROW_CNT_W-1:0]          num_rows,
   input  logic [DESIGN_SIZE-1:0]        validity_mask,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
   output logic                          done_pool
);

   localparam int ACC_W = acc_width(DWIDTH, MAX_WIN);

   pool_state_e                       state_q, state_d;
   logic                              mode_q;
   logic [1:0]                        lg_q, lg_new;
   logic [ROW_CNT_W-1:0]              rows_q, row_cnt_q;
   logic [2:0]                        win_cnt_q, k_m1;
   logic                              rows_done_q;
   logic                              ovld_q;
   logic [DESIGN_SIZE*DWIDTH-1:0]     odat_q, red_dat;
   logic [DESIGN_SIZE-1:0][ACC_W-1:0] acc_q, acc_d;
   logic [DESIGN_SIZE-1:0]            lvld_q, lvld_d;
   logic signed [ACC_W-1:0]           contrib;
   logic                              pool_rdy, accept, is_last, win_end, emit, start_ok;

   assign k_m1     = (3'd1 << lg_q) - 3'd1;
   assign is_last  = (row_cnt_q == rows_q - ROW_CNT_W'(1));
   assign win_end  = (win_cnt_q == k_m1) || is_last;
   // No rows beyond the frame are taken once the last one is in.
   assign pool_rdy = (state_q == ACCUM) && !rows_done_q && (!ovld_q || out_ready);
   assign accept   = in_valid && pool_rdy;
   assign emit     = accept && win_end;
   assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      lg_new = win_log2(pool_window_size);
      if (int'(lg_new) > $clog2(MAX_WIN))
         lg_new = 2'd0;
   end

   always_comb begin
      acc_d   = acc_q;
      lvld_d  = lvld_q;
      contrib = '0;
      for (int i = 0; i < DESIGN_SIZE; i++) begin
         if (validity_mask[i])
            contrib = ACC_W'($signed(inp_data[i*DWIDTH +: DWIDTH]));
         else
            contrib = (mode_q == POOL_MAX) ? {1'b1, {(ACC_W-1){1'b0}}} : '0;
         if (win_cnt_q == 3'd0) begin
            acc_d[i]  = contrib;
            lvld_d[i] = validity_mask[i];
         end else begin
            if (mode_q == POOL_MAX)
               acc_d[i] = (contrib > $signed(acc_q[i])) ? contrib : acc_q[i];
            else
               acc_d[i] = acc_q[i] + contrib;
            lvld_d[i] = lvld_q[i] | validity_mask[i];
         end
      end
   end

   pool_hreduce #(
      .DESIGN_SIZE (DESIGN_SIZE),
      .ACC_W       (ACC_W),
      .DWIDTH      (DWIDTH)
   ) u_hreduce (
      .mode     (mode_q),
      .win_lg   (lg_q),
      .acc      (acc_d),
      .lane_vld (lvld_d),
      .dat      (red_dat)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = (num_rows == '0) ? DONE : ACCUM;
         ACCUM:      if (rows_done_q && ovld_q && out_ready) state_d = DONE;
         default:    state_d = IDLE;
      endcase
      if (!enable_pool)
         state_d = IDLE;
   end

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         mode_q <= POOL_AVG;  lg_q <= '0;  rows_q <= '0;  row_cnt_q <= '0;
         win_cnt_q <= '0;  rows_done_q <= 1'b0;  ovld_q <= 1'b0;  odat_q <= '0;
         acc_q <= '0;  lvld_q <= '0;
      end else if (!enable_pool) begin
         mode_q <= POOL_AVG;  lg_q <= '0;  rows_q <= '0;  row_cnt_q <= '0;
         win_cnt_q <= '0;  rows_done_q <= 1'b0;  ovld_q <= 1'b0;  odat_q <= '0;
         acc_q <= '0;  lvld_q <= '0;
      end else begin
         if (start_ok) begin
            mode_q      <= pool_mode;
            lg_q        <= lg_new;
            rows_q      <= num_rows;
            row_cnt_q   <= '0;
            win_cnt_q   <= '0;
            rows_done_q <= 1'b0;
         end
         if (accept) begin
            row_cnt_q <= row_cnt_q + ROW_CNT_W'(1);
            win_cnt_q <= win_end ? 3'd0 : win_cnt_q + 3'd1;
            acc_q     <= win_end ? '0 : acc_d;
            lvld_q    <= win_end ? '0 : lvld_d;
            if (is_last)
               rows_done_q <= 1'b1;
         end
         if (emit) begin
            ovld_q <= 1'b1;
            odat_q <= red_dat;
         end else if (out_ready) begin
            ovld_q <= 1'b0;
         end
      end
   end

   assign out_data  = enable_pool ? odat_q : inp_data;
   assign out_valid = enable_pool ? ovld_q : in_valid;
   assign in_ready  = enable_pool ? pool_rdy : out_ready;
   assign done_pool = enable_pool ? (state_q == DONE) : 1'b1;

endmodule

// File: tb/tb_pool_2d.sv
// Scoreboard bench for pool_2d at DESIGN_SIZE = 4, DWIDTH = 8 with hand-computed rows.
module tb_pool_2d;
   localparam int DS = 4;
   localparam int DW = 8;
   localparam int RW = 16;

   logic             core_clk = 1'b0;
   logic             arst_n = 1'b0;
   logic             enable_pool = 1'b1;
   logic             start = 1'b0;
   logic             pool_mode = 1'b0;
   logic [2:0]       pool_window_size = 3'd1;
   logic [RW-1:0]    num_rows = '0;
   logic [DS-1:0]    validity_mask = '1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [DS*DW-1:0] inp_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [DS*DW-1:0] out_data;
   logic             done_pool;

   int               checks = 0;
   int               errors = 0;
   logic [DS*DW-1:0] exp_q[$];
   logic [DS*DW-1:0] exp_e;
   logic [DS*DW-1:0] row_a, row_b, row_c, row_m, avg_ab, max_ab, avg_c, mask_r;

   always #5 core_clk = ~core_clk;

   pool_2d #(.DESIGN_SIZE(DS), .DWIDTH(DW), .MAX_WIN(4), .ROW_CNT_W(RW)) dut (
      .core_clk(core_clk), .arst_n(arst_n), .enable_pool(enable_pool), .start(start),
      .pool_mode(pool_mode), .pool_window_size(pool_window_size), .num_rows(num_rows),
      .validity_mask(validity_mask), .in_valid(in_valid), .in_ready(in_ready),
      .inp_data(inp_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .done_pool(done_pool)
   );

   function automatic logic [DS*DW-1:0] row(input int l0, input int l1, input int l2, input int l3);
      return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a transfer happens at the next rising edge whenever valid && ready here.
   always @(negedge core_clk) begin
      if (arst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h expected none", out_data);
         end else begin
            exp_e = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(exp_e));
         end
      end
   end

   task automatic do_start(input logic mode, input logic [2:0] k, input int rows);
      pool_mode = mode;
      pool_window_size = k;
      num_rows = RW'(rows);
      start = 1'b1;
      @(posedge core_clk); #1;
      start = 1'b0;
   endtask

   task automatic send_row(input logic [DS*DW-1:0] d, input logic [DS-1:0] m);
      int n = 0;
      inp_data = d;
      validity_mask = m;
      in_valid = 1'b1;
      @(negedge core_clk);
      while (!in_ready && n < 50) begin
         @(negedge core_clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1");
      end
      @(posedge core_clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      @(negedge core_clk);
      while (!done_pool && n < 50) begin
         @(negedge core_clk);
         n++;
      end
      check(name, 64'(done_pool), 64'd1);
      @(posedge core_clk); #1;
   endtask

   initial begin
      row_a  = row(4, 8, -2, -6);
      row_b  = row(0, 4, 2, -2);
      row_c  = row(8, 8, 8, 8);
      avg_ab = row(4, -2, 0, 0);
      max_ab = row(8, 2, 0, 0);
      avg_c  = row(4, 4, 0, 0);
      row_m  = row(-5, 100, 3, 1);
      mask_r = row(-5, 0, 3, 1);

      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_done", 64'(done_pool), 64'd0);
      repeat (2) @(posedge core_clk);
      #1 arst_n = 1'b1;
      @(posedge core_clk); #1;

      // 1: average, K = 2, two rows
      exp_q.push_back(avg_ab);
      do_start(1'b0, 3'd2, 2);
      send_row(row_a, 4'b1111);
      send_row(row_b, 4'b1111);
      @(negedge core_clk);
      check("s1_out_valid", 64'(out_valid), 64'd1);
      check("s1_done_early", 64'(done_pool), 64'd0);
      @(negedge core_clk);
      check("s1_done", 64'(done_pool), 64'd1);
      @(posedge core_clk); #1;

      // 2: max, K = 2, same rows
      exp_q.push_back(max_ab);
      do_start(1'b1, 3'd2, 2);
      send_row(row_a, 4'b1111);
      send_row(row_b, 4'b1111);
      wait_done("s2_done");

      // 3: output stalled five cycles
      out_ready = 1'b0;
      exp_q.push_back(avg_ab);
      do_start(1'b0, 3'd2, 2);
      send_row(row_a, 4'b1111);
      send_row(row_b, 4'b1111);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge core_clk);
         check("s3_hold_valid", 64'(out_valid), 64'd1);
         check("s3_hold_data", 64'(out_data), 64'(avg_ab));
         check("s3_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge core_clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_done("s3_done");
      @(negedge core_clk);
      check("s3_valid_after", 64'(out_valid), 64'd0);
      @(posedge core_clk); #1;

      // 4: partial last window, back-to-back outputs
      exp_q.push_back(avg_ab);
      exp_q.push_back(avg_c);
      do_start(1'b0, 3'd2, 3);
      send_row(row_a, 4'b1111);
      send_row(row_b, 4'b1111);
      send_row(row_c, 4'b1111);
      wait_done("s4_done");

      // 5: masked lane in max mode, K = 1
      exp_q.push_back(mask_r);
      do_start(1'b1, 3'd1, 1);
      send_row(row_m, 4'b1101);
      wait_done("s5_done");
      validity_mask = 4'b1111;

      // 6a: bypass
      enable_pool = 1'b0;
      inp_data = row_c;
      in_valid = 1'b1;
      exp_q.push_back(row_c);
      #1;
      check("byp_data", 64'(out_data), 64'(row_c));
      check("byp_done", 64'(done_pool), 64'd1);
      check("byp_in_ready", 64'(in_ready), 64'd1);
      @(posedge core_clk); #1;
      inp_data = row_m;
      out_ready = 1'b0;
      #1;
      check("byp_data2", 64'(out_data), 64'(row_m));
      check("byp_in_ready_lo", 64'(in_ready), 64'd0);
      check("byp_valid", 64'(out_valid), 64'd1);
      @(posedge core_clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      enable_pool = 1'b1;
      #1;
      check("idle_done", 64'(done_pool), 64'd0);
      @(posedge core_clk); #1;

      // 6b: reset mid-frame, then a clean frame
      do_start(1'b0, 3'd2, 2);
      send_row(row_a, 4'b1111);
      arst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_data", 64'(out_data), 64'd0);
      check("mid_rst_done", 64'(done_pool), 64'd0);
      @(posedge core_clk); #1;
      arst_n = 1'b1;
      @(posedge core_clk); #1;
      exp_q.push_back(avg_ab);
      do_start(1'b0, 3'd2, 2);
      send_row(row_a, 4'b1111);
      send_row(row_b, 4'b1111);
      wait_done("s6_done");

      repeat (3) @(posedge core_clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
